// File: rtl/lcd_spi_pkg.sv
// Shared types and constants for the LCD SPI write path.
// Holds the serialiser state encoding and the DC line meanings.
package lcd_spi_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } spi_state_t;

   localparam logic DC_CMD   = 1'b0;
   localparam logic DC_DATA  = 1'b1;
   localparam int   LCD_BITS = 8;

endpackage

// File: rtl/lcd_spi_tick.sv
// Half-period tick generator for the SPI serialiser.
// Held cleared while idle so the first tick lands exactly HALF_DIV cycles after launch.
module lcd_spi_tick #(
   parameter int HALF_DIV = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   output logic o_tick
);

   localparam int             CW   = $clog2(HALF_DIV + 1);
   localparam logic [CW-1:0]  LAST = CW'(HALF_DIV - 1);

   logic [CW-1:0] r_phase;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_phase <= '0;
      end else if (r_phase == LAST) begin
         r_phase <= '0;
      end else begin
         r_phase <= r_phase + CW'(1);
      end
   end

   assign o_tick = !i_clear && (r_phase == LAST);

endmodule

// File: rtl/lcd_spi_writer.sv
// Serialises 9-bit LCD write words (DC + byte) into a mode-0 SPI stream.
// A one-deep pending slot absorbs a request arriving while a word is in flight.
module lcd_spi_writer
   import lcd_spi_pkg::*;
#(
   parameter int HALF_DIV = 2,
   parameter int BITS     = LCD_BITS
) (
   input  logic       sys_clk_50MHz,
   input  logic       sys_rst,
   input  logic [8:0] data,
   input  logic       en_write,
   output logic       lcd_sclk,
   output logic       lcd_mosi,
   output logic       lcd_cs_n,
   output logic       lcd_dc,
   output logic       busy,
   output logic       wr_done,
   output logic       overflow
);

   spi_state_t       r_state;
   spi_state_t       w_nextState;
   logic [BITS-1:0]  r_shift;
   logic [3:0]       r_bitCnt;
   logic             r_pendValid;
   logic [8:0]       r_pendData;

   logic             w_tick;
   logic             w_launchable;
   logic             w_launch;
   logic [8:0]       w_launchWord;
   logic             w_fall;
   logic             w_lastFall;

   lcd_spi_tick #(.HALF_DIV(HALF_DIV)) u_tick (
      .i_clk   (sys_clk_50MHz),
      .i_rst   (sys_rst),
      .i_clear (r_state == ST_IDLE),
      .o_tick  (w_tick)
   );

   // The final GAP tick counts as idle so back-to-back words repeat every 18 half-periods.
   assign w_launchable = (r_state == ST_IDLE) || ((r_state == ST_GAP) && w_tick);
   assign w_launch     = w_launchable && (r_pendValid || en_write);
   assign w_launchWord = r_pendValid ? r_pendData : data;
   assign w_fall       = (r_state == ST_SHIFT) && w_tick && lcd_sclk;
   assign w_lastFall   = w_fall && (r_bitCnt == 4'(BITS - 1));
   assign busy         = (r_state != ST_IDLE) || r_pendValid;

   always_ff @(posedge sys_clk_50MHz) begin
      if (sys_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_launch)   w_nextState = ST_SHIFT;
         ST_SHIFT: if (w_lastFall) w_nextState = ST_HOLD;
         ST_HOLD:  if (w_tick)     w_nextState = ST_GAP;
         ST_GAP:   if (w_tick)     w_nextState = w_launch ? ST_SHIFT : ST_IDLE;
         default:                  w_nextState = ST_IDLE;
      endcase
   end

   // Pending data has priority at launch; a simultaneous request refills the freed slot.
   always_ff @(posedge sys_clk_50MHz) begin
      if (sys_rst) begin
         lcd_sclk    <= 1'b0;
         lcd_mosi    <= 1'b0;
         lcd_cs_n    <= 1'b1;
         lcd_dc      <= DC_CMD;
         wr_done     <= 1'b0;
         overflow    <= 1'b0;
         r_shift     <= '0;
         r_bitCnt    <= '0;
         r_pendValid <= 1'b0;
         r_pendData  <= '0;
      end else begin
         wr_done  <= 1'b0;
         overflow <= 1'b0;

         if (w_launch) begin
            r_shift  <= w_launchWord[BITS-1:0];
            lcd_dc   <= w_launchWord[8];
            lcd_cs_n <= 1'b0;
            lcd_mosi <= w_launchWord[BITS-1];
            lcd_sclk <= 1'b0;
            r_bitCnt <= '0;
         end else if ((r_state == ST_SHIFT) && w_tick) begin
            lcd_sclk <= !lcd_sclk;
            if (w_fall) begin
               if (r_bitCnt != 4'(BITS)) begin
                  r_bitCnt <= r_bitCnt + 4'd1;
               end
               if (r_bitCnt < 4'(BITS - 1)) begin
                  r_shift  <= {r_shift[BITS-2:0], 1'b0};
                  lcd_mosi <= r_shift[BITS-2];
               end
            end
         end else if ((r_state == ST_HOLD) && w_tick) begin
            lcd_cs_n <= 1'b1;
            wr_done  <= 1'b1;
         end

         if (en_write) begin
            if (w_launchable) begin
               if (r_pendValid) begin
                  r_pendData <= data;
               end
            end else if (!r_pendValid) begin
               r_pendData  <= data;
               r_pendValid <= 1'b1;
            end else begin
               overflow <= 1'b1;
            end
         end else if (w_launch) begin
            r_pendValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Scoreboard bench for lcd_spi_writer, run at HALF_DIV = 2 and HALF_DIV = 1 side by side.
// A transaction-level model predicts launch times, bytes and dropped requests.
module tb_lcd_spi_writer;
   import lcd_spi_pkg::*;

   typedef struct {
      logic        dc;
      logic [7:0]  byt;
      longint      t0;
   } word_t;

   logic   clk = 1'b0;
   longint cyc = 0;
   int     errors = 0;
   int     checks = 0;
   bit     laneDone [2];

   always #5 clk = ~clk;

   // Edge index: the value seen at a negedge names the posedge just taken.
   always @(posedge clk) cyc <= cyc + 1;

   // Every comparison in the bench funnels through here.
   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int     H    = (g == 0) ? 2 : 1;
      localparam longint WORD = 18 * H;

      logic       rst;
      logic       enW;
      logic [8:0] dat;
      logic       sclk, mosi, csN, dc, busy, wrDone, ovf;

      word_t      expQ [$];
      longint     ovfQ [$];
      longint     lastL = -1000;
      bit         abortExp = 1'b0;

      lcd_spi_writer #(.HALF_DIV(H), .BITS(8)) dut (
         .sys_clk_50MHz (clk),
         .sys_rst       (rst),
         .data          (dat),
         .en_write      (enW),
         .lcd_sclk      (sclk),
         .lcd_mosi      (mosi),
         .lcd_cs_n      (csN),
         .lcd_dc        (dc),
         .busy          (busy),
         .wr_done       (wrDone),
         .overflow      (ovf)
      );

      // Reference model: each accepted word occupies 18H cycles; one word may wait behind it.
      task automatic modelRequest(logic [8:0] d, longint t);
         word_t  w;
         longint launchAt;
         if (t >= lastL + WORD) begin
            launchAt = t;
         end else if (lastL > t) begin
            ovfQ.push_back(t);
            return;
         end else begin
            launchAt = lastL + WORD;
         end
         w.dc  = d[8];
         w.byt = d[7:0];
         w.t0  = launchAt;
         expQ.push_back(w);
         lastL = launchAt;
      endtask

      // Called at a negedge; the request is sampled at the following posedge.
      task automatic applyStimulus(logic [8:0] d);
         modelRequest(d, cyc + 1);
         dat = d;
         enW = 1'b1;
         @(negedge clk);
         enW = 1'b0;
         dat = 9'($urandom);
      endtask

      task automatic idle(int n);
         repeat (n) @(negedge clk);
      endtask

      task automatic waitEdge(longint t);
         while (cyc + 1 < t) @(negedge clk);
      endtask

      initial begin : stim
         longint tr;
         int     bound;
         rst = 1'b1;
         enW = 1'b0;
         dat = '0;
         idle(3);
         checkOutput("rstCsN", csN, 1);
         checkOutput("rstSclk", sclk, 0);
         checkOutput("rstMosi", mosi, 0);
         checkOutput("rstDc", dc, 0);
         checkOutput("rstBusy", busy, 0);
         checkOutput("rstDone", wrDone, 0);
         checkOutput("rstOvf", ovf, 0);
         rst = 1'b0;
         idle(1);

         applyStimulus(9'h1A5);
         idle(40);
         applyStimulus(9'h02A);
         idle(40);
         applyStimulus(9'h111);
         idle(1);
         applyStimulus(9'h122);
         applyStimulus(9'h133);
         idle(80);

         applyStimulus(9'h100);
         applyStimulus({DC_DATA, 8'h55});
         waitEdge(lastL);
         applyStimulus({DC_CMD, 8'hAA});
         idle(100);

         tr = cyc;
         applyStimulus(9'h1C3);
         waitEdge(tr + 11);
         abortExp = 1'b1;
         void'(expQ.pop_back());
         lastL = -1000;
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         checkOutput("midRstCsN", csN, 1);
         checkOutput("midRstSclk", sclk, 0);
         checkOutput("midRstBusy", busy, 0);
         checkOutput("midRstDone", wrDone, 0);
         applyStimulus(9'h1FF);
         idle(40);
         applyStimulus(9'h180);
         idle(40);

         repeat (40) begin
            idle($urandom_range(0, 40));
            applyStimulus(9'($urandom));
         end

         bound = 0;
         while ((expQ.size() != 0 || ovfQ.size() != 0) && bound < 3000) begin
            @(negedge clk);
            bound++;
         end
         idle(5);
         checkOutput("drainWords", expQ.size(), 0);
         checkOutput("drainOvf", ovfQ.size(), 0);
         checkOutput("busyEnd", busy, 0);
         laneDone[g] = 1'b1;
      end

      // Monitor: decodes the SPI lines and pops the scoreboard on every wr_done/overflow.
      initial begin : mon
         bit         inWord;
         longint     t0;
         logic       dcW;
         logic [7:0] got;
         int         nRise;
         bit         timingOk;
         bit         dcOk;
         logic       prevSclk;
         logic       prevCs;
         word_t      e;
         inWord   = 1'b0;
         prevSclk = 1'b0;
         prevCs   = 1'b1;
         t0 = 0; dcW = 1'b0; got = '0; nRise = 0; timingOk = 1'b1; dcOk = 1'b1;
         forever begin
            @(negedge clk);
            if (ovf === 1'b1) begin
               if (ovfQ.size() == 0) checkOutput("ovfUnexpected", cyc, -1);
               else checkOutput("ovfTime", cyc, ovfQ.pop_front());
            end
            if (prevCs === 1'b1 && csN === 1'b0) begin
               inWord = 1'b1; t0 = cyc; dcW = dc; got = '0;
               nRise = 0; timingOk = 1'b1; dcOk = 1'b1;
            end
            if (inWord) begin
               if (dc !== dcW) dcOk = 1'b0;
               if (sclk === 1'b1 && prevSclk === 1'b0) begin
                  if (cyc != t0 + longint'(2 * nRise + 1) * H) timingOk = 1'b0;
                  got = {got[6:0], mosi};
                  nRise++;
               end
               if (wrDone === 1'b1) begin
                  inWord = 1'b0;
                  checkOutput("csHighAtDone", csN, 1);
                  checkOutput("doneTime", cyc, t0 + 17 * H);
                  checkOutput("riseCount", nRise, 8);
                  checkOutput("sclkTiming", timingOk, 1);
                  checkOutput("dcStable", dcOk, 1);
                  if (expQ.size() == 0) begin
                     checkOutput("wordUnexpected", got, -1);
                  end else begin
                     e = expQ.pop_front();
                     checkOutput("launchTime", t0, e.t0);
                     checkOutput("dcValue", dcW, e.dc);
                     checkOutput("byteValue", got, e.byt);
                  end
               end else if (csN === 1'b1) begin
                  inWord = 1'b0;
                  checkOutput("abortExpected", abortExp, 1);
                  abortExp = 1'b0;
               end
            end else if (wrDone === 1'b1) begin
               checkOutput("doneWithoutWord", wrDone, 0);
            end
            prevCs   = csN;
            prevSclk = sclk;
         end
      end
   end

   initial begin : summary
      repeat (60000) begin
         @(negedge clk);
         if (laneDone[0] && laneDone[1]) break;
      end
      checkOutput("lanesFinished", {62'd0, laneDone[1], laneDone[0]}, 3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lcd_spi_writer.md
Name: lcd_spi_writer

Overview:
Serialises 9-bit LCD write words from the init/show-picture arbitration stage into a 4-wire SPI stream for the LCD panel: SCLK, MOSI, CS_N and DC. It is the stage directly downstream of the control mux and consumes its data[8:0]/en_write pair. bit[8] selects the DC line (0 = command, 1 = pixel/parameter data) and bits[7:0] are shifted MSB first. A one-deep pending buffer absorbs a write request that arrives while a byte is still being shifted.

Parameters:
HALF_DIV, 2, sys_clk_50MHz cycles per SCLK half-period (legal range 1..255; 2 gives 12.5 MHz SCLK)
BITS, 8, payload bits per word shifted on MOSI (fixed to 8 for this panel)

Ports:
sys_clk_50MHz  in  1  system clock, 50 MHz
sys_rst  in  1  reset; synchronous, active-high
data  in  9  write word; [8] = DC value, [7:0] = byte, sampled only when en_write = 1
en_write  in  1  single-cycle write request
lcd_sclk  out  1  SPI clock, mode 0 (idles low)
lcd_mosi  out  1  serial data, MSB first
lcd_cs_n  out  1  chip select, active low
lcd_dc  out  1  data/command select, held for the whole word
busy  out  1  high when state != IDLE or the pending buffer is valid
wr_done  out  1  one-cycle pulse when a word completes
overflow  out  1  one-cycle pulse when a request is dropped

Behaviour:
- Reset values (sys_rst sampled high at any clock edge, including mid-transfer):
  - lcd_sclk = 0, lcd_mosi = 0, lcd_cs_n = 1, lcd_dc = 0.
  - busy = 0, wr_done = 0, overflow = 0.
  - Pending buffer invalid, FSM in IDLE, all counters 0.
  - A word in flight is abandoned with no wr_done pulse.
- FSM states: IDLE, SHIFT, HOLD, GAP.
- Edge E0 is the edge where a word launches: in IDLE, en_write = 1 or pending valid.
  - At E0: latch the shift register from data[7:0], set lcd_dc <= data[8], lcd_cs_n <= 0, lcd_mosi <= bit7, enter SHIFT.
  - Pending has priority over a simultaneous en_write. In that case the new request is written into the freed pending slot at the same edge.
- SHIFT timing, with H = HALF_DIV:
  - Bit k (k = 0..7, MSB first) has its rising SCLK edge registered at E0 + (2k+1)H.
  - The matching falling edge is at E0 + (2k+2)H.
  - lcd_mosi updates to the next bit on each falling edge. The peripheral samples on the rising edge.
  - After the 8th falling edge (E0 + 16H), enter HOLD. lcd_cs_n stays low and lcd_mosi stays at bit0.
- HOLD lasts H cycles. At E0 + 17H: lcd_cs_n <= 1, wr_done = 1 for that one cycle, enter GAP.
- GAP lasts H cycles with lcd_cs_n high, then IDLE.
  - Earliest next launch is E0 + 18H (36 cycles per word at H = 2).
  - Sustained throughput is one word per 18H cycles.
- Request handling while not launchable (state != IDLE):
  - Pending empty: store data into pending.
  - Pending full: drop the request and pulse overflow for one cycle.
  - Pending and IDLE-launch events at the same edge follow the E0 rule above.
- lcd_dc is updated only at launch, so DC never changes while lcd_cs_n is low.
- Internal counters:
  - Phase counter width is $clog2(HALF_DIV+1), wrapping at HALF_DIV-1.
  - Bit counter is 4 bits and saturates at BITS; no wrap-around inside a word.
- en_write on consecutive cycles: the first launches or buffers, the second buffers or overflows. There is no stall signal upstream.

Decomposition:
- Shared package lcd_spi_pkg:
  - FSM state enum (IDLE, SHIFT, HOLD, GAP).
  - DC_CMD = 1'b0, DC_DATA = 1'b1.
  - LCD_BITS = 8.
- One sub-module, lcd_spi_tick: HALF_DIV phase counter producing a one-cycle half-period tick. It is held cleared while in IDLE, so the first tick is exactly H cycles after E0.

Test Plan:
- Reset then en_write with data = 9'h1A5, H = 2 -> lcd_cs_n low at E0; lcd_dc = 1; MOSI sampled on 8 rising SCLK edges = 1,0,1,0,0,1,0,1; rising edges at E0+2, +6, ..., +30; wr_done pulse at E0+34; lcd_cs_n high at E0+34.
- Command word 9'h02A -> lcd_dc = 0 during the whole CS-low window; bits 00101010; exactly one wr_done.
- en_write 9'h111 then 9'h122 two cycles later, then 9'h133 one cycle after that -> 0x11 and 0x22 are sent back to back; second launch at E0+36; overflow pulses once on the 0x33 request; exactly two wr_done pulses.
- en_write at the same edge the FSM returns to IDLE with pending holding 9'h155, new data 9'h0AA -> 0x55 launches first with DC = 1, then 0xAA with DC = 0; no overflow.
- Assert sys_rst at E0+11 (mid-byte) -> next edge: lcd_cs_n = 1, lcd_sclk = 0, busy = 0; no wr_done; a following en_write of 9'h1FF transmits cleanly.
- HALF_DIV = 1 build, en_write 9'h180 -> SCLK period 2 cycles; wr_done at E0+17; MOSI = 1 then seven zeros.
